// File: rtl/wca_lime_pkg.sv
// Shared types and constants for the Lime baseband interface emulator.
// Mode encodings, fixed RX pattern, IQ select polarity and TX capture states.
package wca_lime_pkg;

  typedef enum logic [1:0] {
    LIME_RX_LOOP  = 2'd0,
    LIME_RX_RAMP  = 2'd1,
    LIME_RX_FIXED = 2'd2,
    LIME_RX_ZERO  = 2'd3
  } lime_rx_mode_e;

  localparam logic [11:0] LIME_FIXED_I = 12'h100;
  localparam logic [11:0] LIME_FIXED_Q = 12'hF00;

  localparam logic IQSEL_I = 1'b1;

  typedef enum logic {
    TX_WAIT_I = 1'b0,
    TX_WAIT_Q = 1'b1
  } lime_tx_state_e;

  typedef struct packed {
    logic [11:0] q;
    logic [11:0] i;
  } iq_pair_t;

endpackage

// File: rtl/wca_lime_fifo.sv
// Single-clock 24-bit pair FIFO; head is readable combinationally, 1-cycle write-to-read.
// A write when full is refused unless a read happens on the same edge; a read+write always moves both pointers.
module wca_lime_fifo
  import wca_lime_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_wr_vld,
  input  logic [23:0] i_wr_dat,
  input  logic        i_rd_rdy,
  output logic [23:0] o_rd_dat,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr_ok;
  logic          w_rd_ok;

  assign o_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_rd_dat = r_mem[r_rd_ptr];

  // A paired read+write on an empty FIFO lets the read pointer skip over the new entry.
  assign w_wr_ok = i_wr_vld && (!o_full || i_rd_rdy);
  assign w_rd_ok = i_rd_rdy && (!o_empty || i_wr_vld);

  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
    end
  end

endmodule

// File: rtl/wca_lime_emu.sv
// Lime transceiver emulator: TX pair capture (strobe 1 cycle after Q), RX word generator, loopback FIFO; no backpressure.
// Framing error counter enabled by WCA_LIME_EMU_FRAMECHK_EN; otherwise frame_err_count is tied to 0.
module wca_lime_emu
  import wca_lime_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        rf_txen,
  input  logic        rf_txiqsel,
  input  logic [11:0] rf_txdata,
  input  logic        rf_rxen,
  output logic        rf_rxiqsel,
  output logic [11:0] rf_rxdata,
  output logic [23:0] tx_iq,
  output logic        tx_strobe,
  output logic        fifo_overrun,
  output logic        fifo_underrun,
  output logic [7:0]  frame_err_count
);

  lime_rx_mode_e  w_mode;
  lime_tx_state_e r_tx_state;
  logic [11:0]    r_held_i;
  logic [23:0]    r_tx_iq;
  logic           r_tx_strobe;

  logic           r_rx_phase_q;
  logic           r_rxiqsel;
  logic [11:0]    r_rxdata;
  logic [11:0]    r_q_hold;
  logic [11:0]    r_ramp;
  logic           r_overrun;
  logic           r_underrun;

  logic           w_fifo_wr;
  logic           w_pop;
  logic           w_fetch;
  logic [23:0]    w_fifo_dat;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  iq_pair_t       w_pair;

  assign w_mode = lime_rx_mode_e'(mode);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_state  <= TX_WAIT_I;
      r_held_i    <= '0;
      r_tx_iq     <= '0;
      r_tx_strobe <= 1'b0;
    end else begin
      r_tx_strobe <= 1'b0;
      if (!rf_txen) begin
        r_tx_state <= TX_WAIT_I;
      end else begin
        case (r_tx_state)
          TX_WAIT_I: begin
            if (rf_txiqsel == IQSEL_I) begin
              r_held_i   <= rf_txdata;
              r_tx_state <= TX_WAIT_Q;
            end
          end
          TX_WAIT_Q: begin
            // A repeated I word replaces the held one so the newest I pairs with the next Q.
            if (rf_txiqsel == IQSEL_I) begin
              r_held_i <= rf_txdata;
            end else begin
              r_tx_iq     <= {rf_txdata, r_held_i};
              r_tx_strobe <= 1'b1;
              r_tx_state  <= TX_WAIT_I;
            end
          end
          default: r_tx_state <= TX_WAIT_I;
        endcase
      end
    end
  end

  assign tx_iq     = r_tx_iq;
  assign tx_strobe = r_tx_strobe;

  assign w_fifo_wr = r_tx_strobe && (w_mode == LIME_RX_LOOP);
  assign w_fetch   = rf_rxen && !r_rx_phase_q;
  assign w_pop     = w_fetch && (w_mode == LIME_RX_LOOP);

  wca_lime_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .i_wr_vld (w_fifo_wr),
    .i_wr_dat (r_tx_iq),
    .i_rd_rdy (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  always_comb begin
    w_pair = '0;
    case (w_mode)
      LIME_RX_LOOP:  w_pair = w_fifo_empty ? '0 : iq_pair_t'(w_fifo_dat);
      LIME_RX_RAMP:  w_pair = '{q: ~r_ramp, i: r_ramp};
      LIME_RX_FIXED: w_pair = '{q: LIME_FIXED_Q, i: LIME_FIXED_I};
      default:       w_pair = '0;
    endcase
  end

  // The Q word is latched with its I so a mode change mid-pair cannot split the pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_phase_q <= 1'b0;
      r_rxiqsel    <= 1'b0;
      r_rxdata     <= '0;
      r_q_hold     <= '0;
      r_ramp       <= '0;
      r_underrun   <= 1'b0;
    end else if (!rf_rxen) begin
      r_rx_phase_q <= 1'b0;
      r_rxiqsel    <= 1'b0;
      r_rxdata     <= '0;
    end else if (!r_rx_phase_q) begin
      r_rx_phase_q <= 1'b1;
      r_rxiqsel    <= IQSEL_I;
      r_rxdata     <= w_pair.i;
      r_q_hold     <= w_pair.q;
      if (w_mode == LIME_RX_RAMP) begin
        r_ramp <= r_ramp + 12'd1;
      end
      if (w_pop && w_fifo_empty) begin
        r_underrun <= 1'b1;
      end
    end else begin
      r_rx_phase_q <= 1'b0;
      r_rxiqsel    <= ~IQSEL_I;
      r_rxdata     <= r_q_hold;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_fifo_wr && w_fifo_full && !w_pop) begin
      r_overrun <= 1'b1;
    end
  end

  assign rf_rxiqsel    = r_rxiqsel;
  assign rf_rxdata     = r_rxdata;
  assign fifo_overrun  = r_overrun;
  assign fifo_underrun = r_underrun;

`ifdef WCA_LIME_EMU_FRAMECHK_EN
  logic       w_frame_err;
  logic [7:0] r_frame_err_cnt;

  assign w_frame_err = rf_txen &&
                       ((r_tx_state == TX_WAIT_I) ? (rf_txiqsel != IQSEL_I)
                                                  : (rf_txiqsel == IQSEL_I));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_err_cnt <= '0;
    end else if (w_frame_err && (r_frame_err_cnt != 8'hFF)) begin
      r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
    end
  end

  assign frame_err_count = r_frame_err_cnt;
`else
  assign frame_err_count = 8'd0;
`endif

endmodule
